// File: rtl/exe_issue_driver.sv
// exe_issue_driver: age-ordered collapsing issue buffer driving one ALU/DIV unit's registered request port.
// Define EXE_ISSUE_DRIVER_BYPASS_EN to let an eligible micro-op skip an empty queue straight into the request register.
module exe_issue_driver #(
   parameter int DEPTH = 4,
   localparam int CW = $clog2(DEPTH) + 1
) (
   input  logic          clock,
   input  logic          reset,
   input  logic          io_enq_valid,
   output logic          io_enq_ready,
   input  logic [6:0]    io_enq_bits_uopc,
   input  logic [9:0]    io_enq_bits_fu_code,
   input  logic [19:0]   io_enq_bits_br_mask,
   input  logic [6:0]    io_enq_bits_rob_idx,
   input  logic [6:0]    io_enq_bits_pdst,
   input  logic [64:0]   io_enq_bits_rs1_data,
   input  logic [64:0]   io_enq_bits_rs2_data,
   input  logic [9:0]    io_fu_types,
   input  logic [19:0]   io_brupdate_b1_resolve_mask,
   input  logic [19:0]   io_brupdate_b1_mispredict_mask,
   input  logic          io_flush,
   output logic          io_req_valid,
   output logic [6:0]    io_req_bits_uopc,
   output logic [9:0]    io_req_bits_fu_code,
   output logic [19:0]   io_req_bits_br_mask,
   output logic [6:0]    io_req_bits_rob_idx,
   output logic [6:0]    io_req_bits_pdst,
   output logic [64:0]   io_req_bits_rs1_data,
   output logic [64:0]   io_req_bits_rs2_data,
   output logic          io_req_bits_kill,
   output logic [CW-1:0] io_count
);
   typedef struct packed {
      logic [6:0]  uopc;
      logic [9:0]  fu_code;
      logic [19:0] br_mask;
      logic [6:0]  rob_idx;
      logic [6:0]  pdst;
      logic [64:0] rs1_data;
      logic [64:0] rs2_data;
   } uop_t;
   uop_t q [DEPTH];
   uop_t nq [DEPTH];
   uop_t e, s, r, rn;
   logic [DEPTH-1:0] live, keep;
   logic [CW-1:0] nc;
   logic found, e_fire, e_dead, e_wr, byp;
   int sidx, rank;
   assign e = {io_enq_bits_uopc, io_enq_bits_fu_code, io_enq_bits_br_mask, io_enq_bits_rob_idx,
               io_enq_bits_pdst, io_enq_bits_rs1_data, io_enq_bits_rs2_data};
   assign io_enq_ready = io_count != CW'(DEPTH);
   assign e_fire = io_enq_valid & io_enq_ready;
   assign e_dead = io_flush | |(io_enq_bits_br_mask & io_brupdate_b1_mispredict_mask);
`ifdef EXE_ISSUE_DRIVER_BYPASS_EN
   assign byp = e_fire & (io_count == '0) & |(io_enq_bits_fu_code & io_fu_types) & ~e_dead;
`else
   assign byp = 1'b0;
`endif
   assign e_wr = e_fire & ~e_dead & ~byp;
   // Select the oldest eligible entry, then squeeze survivors (and the new micro-op) toward index 0.
   always_comb begin
      found = 1'b0;
      sidx = 0;
      s = '0;
      rank = 0;
      live = '0;
      keep = '0;
      nq = '{default: '0};
      for (int i = 0; i < DEPTH; i++) begin
         live[i] = (CW'(i) < io_count) & ~io_flush & ~|(q[i].br_mask & io_brupdate_b1_mispredict_mask);
         if (!found && live[i] && |(q[i].fu_code & io_fu_types)) begin
            found = 1'b1;
            sidx = i;
            s = q[i];
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         keep[i] = live[i] & ~(found && sidx == i);
         for (int j = 0; j < DEPTH; j++)
            if (keep[i] && rank == j) begin
               nq[j] = q[i];
               nq[j].br_mask = q[i].br_mask & ~io_brupdate_b1_resolve_mask;
            end
         if (keep[i]) rank = rank + 1;
      end
      for (int j = 0; j < DEPTH; j++)
         if (e_wr && rank == j) begin
            nq[j] = e;
            nq[j].br_mask = e.br_mask & ~io_brupdate_b1_resolve_mask;
         end
      nc = CW'(rank) + CW'(e_wr);
      rn = found ? s : byp ? e : r;
      rn.br_mask = rn.br_mask & ~io_brupdate_b1_resolve_mask;
   end
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q <= '{default: '0};
         io_count <= '0;
         io_req_valid <= 1'b0;
         r <= '0;
      end else begin
         q <= nq;
         io_count <= nc;
         io_req_valid <= found | byp;
         r <= rn;
      end
   end
   assign io_req_bits_uopc = r.uopc;
   assign io_req_bits_fu_code = r.fu_code;
   assign io_req_bits_br_mask = r.br_mask;
   assign io_req_bits_rob_idx = r.rob_idx;
   assign io_req_bits_pdst = r.pdst;
   assign io_req_bits_rs1_data = r.rs1_data;
   assign io_req_bits_rs2_data = r.rs2_data;
   assign io_req_bits_kill = io_req_valid & (io_flush | |(r.br_mask & io_brupdate_b1_mispredict_mask));
endmodule

// File: tb/tb_exe_issue_driver.sv
// tb_exe_issue_driver: directed plus random stimulus checked against a queue-based reference model of the issue driver.
module tb_exe_issue_driver;
   localparam int DEPTH = 4;
`ifdef EXE_ISSUE_DRIVER_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif
   typedef struct packed {
      logic [6:0]  uopc;
      logic [9:0]  fu_code;
      logic [19:0] br_mask;
      logic [6:0]  rob_idx;
      logic [6:0]  pdst;
      logic [64:0] rs1_data;
      logic [64:0] rs2_data;
   } u_t;
   logic clock = 1'b0;
   logic reset;
   logic io_enq_valid;
   u_t e;
   logic [9:0] fut_base, io_fu_types;
   logic [19:0] res, misp;
   logic flush;
   logic io_enq_ready, io_req_valid, io_req_bits_kill;
   logic [6:0] io_req_bits_uopc, io_req_bits_rob_idx, io_req_bits_pdst;
   logic [9:0] io_req_bits_fu_code;
   logic [19:0] io_req_bits_br_mask;
   logic [64:0] io_req_bits_rs1_data, io_req_bits_rs2_data;
   logic [2:0] io_count;
   int vectors = 0, errs = 0;
   u_t mq[$];
   bit mrv;
   u_t mr;
   int cyc_n, first_v, last_v;
   int seen[$];
   logic [9:0] fus [4] = '{10'h001, 10'h010, 10'h011, 10'h002};
   logic [9:0] futs [4] = '{10'h011, 10'h001, 10'h010, 10'h000};
   always #5 clock = ~clock;
   exe_issue_driver #(.DEPTH(DEPTH)) dut (
      .clock(clock), .reset(reset),
      .io_enq_valid(io_enq_valid), .io_enq_ready(io_enq_ready),
      .io_enq_bits_uopc(e.uopc), .io_enq_bits_fu_code(e.fu_code), .io_enq_bits_br_mask(e.br_mask),
      .io_enq_bits_rob_idx(e.rob_idx), .io_enq_bits_pdst(e.pdst),
      .io_enq_bits_rs1_data(e.rs1_data), .io_enq_bits_rs2_data(e.rs2_data),
      .io_fu_types(io_fu_types),
      .io_brupdate_b1_resolve_mask(res), .io_brupdate_b1_mispredict_mask(misp), .io_flush(flush),
      .io_req_valid(io_req_valid),
      .io_req_bits_uopc(io_req_bits_uopc), .io_req_bits_fu_code(io_req_bits_fu_code),
      .io_req_bits_br_mask(io_req_bits_br_mask), .io_req_bits_rob_idx(io_req_bits_rob_idx),
      .io_req_bits_pdst(io_req_bits_pdst), .io_req_bits_rs1_data(io_req_bits_rs1_data),
      .io_req_bits_rs2_data(io_req_bits_rs2_data), .io_req_bits_kill(io_req_bits_kill),
      .io_count(io_count)
   );
   function automatic bit hits(input logic [19:0] m);
      return (m & misp) != 20'h0;
   endfunction
   task automatic chk(input string tag, input logic [199:0] o, input logic [199:0] x);
      vectors++;
      assert (o === x) else begin
         errs++;
         $error("FAIL %s observed=%0h expected=%0h", tag, o, x);
      end
   endtask
   task automatic put(input bit v, input logic [9:0] fu, input logic [19:0] br, input logic [6:0] rob);
      io_enq_valid = v;
      e.uopc = 7'($urandom);
      e.fu_code = fu;
      e.br_mask = br;
      e.rob_idx = rob;
      e.pdst = 7'($urandom);
      e.rs1_data = {1'($urandom), $urandom, $urandom};
      e.rs2_data = {1'($urandom), $urandom, $urandom};
   endtask
   // Reference: oldest eligible survivor issues; killed ones vanish; the rest keep age order.
   task automatic model_step();
      bit acc, fnd, dead, bp;
      int idx;
      u_t sel, ee;
      u_t nq[$];
      acc = io_enq_valid && mq.size() != DEPTH;
      fnd = 0;
      idx = -1;
      sel = '0;
      foreach (mq[i])
         if (!fnd && (mq[i].fu_code & io_fu_types) != 10'h0 && !flush && !hits(mq[i].br_mask)) begin
            fnd = 1;
            idx = i;
            sel = mq[i];
         end
      foreach (mq[i])
         if (i != idx && !flush && !hits(mq[i].br_mask)) begin
            ee = mq[i];
            ee.br_mask = ee.br_mask & ~res;
            nq.push_back(ee);
         end
      dead = flush || hits(e.br_mask);
      bp = BYP && acc && mq.size() == 0 && (e.fu_code & io_fu_types) != 10'h0 && !dead;
      ee = e;
      ee.br_mask = ee.br_mask & ~res;
      if (acc && !dead && !bp) nq.push_back(ee);
      if (fnd) begin
         mr = sel;
         mr.br_mask = mr.br_mask & ~res;
      end else if (bp) mr = ee;
      else mr.br_mask = mr.br_mask & ~res;
      mrv = fnd || bp;
      mq = nq;
   endtask
   task automatic cyc();
      io_fu_types = fut_base & ((mrv && mr.fu_code[4]) ? 10'h3ef : 10'h3ff);
      #1;
      chk("kill", 200'(io_req_bits_kill), 200'(mrv && (flush || hits(mr.br_mask))));
      chk("enq_ready", 200'(io_enq_ready), 200'(mq.size() != DEPTH));
      model_step();
      @(posedge clock);
      #1;
      cyc_n++;
      chk("req_valid", 200'(io_req_valid), 200'(mrv));
      chk("req_bits", 200'({io_req_bits_uopc, io_req_bits_fu_code, io_req_bits_br_mask, io_req_bits_rob_idx,
                            io_req_bits_pdst, io_req_bits_rs1_data, io_req_bits_rs2_data}), 200'(mr));
      chk("count", 200'(io_count), 200'(mq.size()));
      if (io_req_valid) begin
         seen.push_back(int'(io_req_bits_rob_idx));
         if (first_v < 0) first_v = cyc_n;
         last_v = cyc_n;
      end
   endtask
   initial begin
      reset = 1'b1;
      put(0, 0, 0, 0);
      fut_base = 0; io_fu_types = 0; res = 0; misp = 0; flush = 0;
      mrv = 0; mr = '0;
      repeat (2) @(posedge clock);
      #1;
      chk("rst_valid", 200'(io_req_valid), 200'(0));
      chk("rst_kill", 200'(io_req_bits_kill), 200'(0));
      chk("rst_count", 200'(io_count), 200'(0));
      chk("rst_ready", 200'(io_enq_ready), 200'(1));
      chk("rst_bits", 200'({io_req_bits_uopc, io_req_bits_fu_code, io_req_bits_br_mask, io_req_bits_rob_idx,
                            io_req_bits_pdst, io_req_bits_rs1_data, io_req_bits_rs2_data}), 200'(0));
      reset = 1'b0;
      // ALU stream
      fut_base = 10'h011; cyc_n = 0; first_v = -1; last_v = -1; seen = {};
      for (int k = 0; k < 4; k++) begin
         put(1, 10'h001, 0, 7'(k));
         cyc();
      end
      put(0, 0, 0, 0);
      repeat (4) cyc();
      chk("alu_first", 200'(first_v), 200'(2 - int'(BYP)));
      chk("alu_back2back", 200'(last_v - first_v), 200'(3));
      chk("alu_n", 200'(seen.size()), 200'(4));
      foreach (seen[k]) chk("alu_order", 200'(seen[k]), 200'(k));
      // divider blocked, younger ALU overtakes
      fut_base = 10'h001; seen = {};
      put(1, 10'h010, 0, 5); cyc();
      put(1, 10'h001, 0, 6); cyc();
      put(0, 0, 0, 0);
      repeat (3) cyc();
      fut_base = 10'h011;
      repeat (3) cyc();
      chk("div_n", 200'(seen.size()), 200'(2));
      if (seen.size() == 2) begin
         chk("div_first", 200'(seen[0]), 200'(6));
         chk("div_second", 200'(seen[1]), 200'(5));
      end
      // partial mispredict kill
      fut_base = 0; seen = {};
      put(1, 10'h001, 20'h1, 10); cyc();
      put(1, 10'h001, 20'h2, 11); cyc();
      put(1, 10'h001, 20'h1, 12); cyc();
      put(1, 10'h001, 20'h0, 13); cyc();
      put(0, 0, 0, 0);
      chk("pk_before", 200'(io_count), 200'(4));
      misp = 20'h1; cyc(); misp = 0;
      chk("pk_after", 200'(io_count), 200'(2));
      fut_base = 10'h001;
      repeat (3) cyc();
      chk("pk_n", 200'(seen.size()), 200'(2));
      if (seen.size() == 2) begin
         chk("pk_first", 200'(seen[0]), 200'(11));
         chk("pk_second", 200'(seen[1]), 200'(13));
      end
      // resolve in queue, then kill in flight
      fut_base = 0;
      put(1, 10'h001, 20'h2, 20); cyc();
      put(0, 0, 0, 0);
      res = 20'h2; cyc(); res = 0;
      fut_base = 10'h001; cyc();
      chk("res_valid", 200'(io_req_valid), 200'(1));
      chk("res_br", 200'(io_req_bits_br_mask), 200'(0));
      cyc();
      put(1, 10'h001, 20'h4, 21); cyc();
      put(0, 0, 0, 0);
      for (int k = 0; k < 4 && !io_req_valid; k++) cyc();
      chk("inflight_valid", 200'(io_req_valid), 200'(1));
      misp = 20'h4;
      #1;
      chk("inflight_kill", 200'(io_req_bits_kill), 200'(1));
      cyc(); misp = 0;
      // full queue then flush
      fut_base = 0;
      for (int k = 0; k < 5; k++) begin
         put(1, 10'h001, 0, 7'(30 + k));
         cyc();
         if (k == 3) chk("full_ready", 200'(io_enq_ready), 200'(0));
      end
      put(0, 0, 0, 0);
      chk("full_count", 200'(io_count), 200'(4));
      flush = 1; cyc(); flush = 0;
      chk("flush_count", 200'(io_count), 200'(0));
      chk("flush_ready", 200'(io_enq_ready), 200'(1));
      // asynchronous reset while a request is in flight
      fut_base = 10'h001;
      put(1, 10'h001, 0, 40); cyc();
      put(0, 0, 0, 0);
      for (int k = 0; k < 4 && !io_req_valid; k++) cyc();
      chk("ar_pre_valid", 200'(io_req_valid), 200'(1));
      #1 reset = 1'b1;
      #1;
      chk("ar_valid", 200'(io_req_valid), 200'(0));
      chk("ar_count", 200'(io_count), 200'(0));
      chk("ar_ready", 200'(io_enq_ready), 200'(1));
      mq = {}; mrv = 0; mr = '0;
      @(posedge clock);
      #1 reset = 1'b0;
      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         put(($urandom % 4) != 0, fus[$urandom % 4], 20'($urandom_range(0, 15)), 7'($urandom));
         fut_base = futs[$urandom % 4];
         res = ($urandom % 2 == 0) ? 20'($urandom_range(0, 15)) : 20'h0;
         misp = ($urandom % 8 == 0) ? (20'h1 << $urandom_range(0, 3)) : 20'h0;
         flush = ($urandom % 40) == 0;
         cyc();
      end
      put(0, 0, 0, 0); res = 0; misp = 0; flush = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
      $finish;
   end
endmodule

// File: doc/exe_issue_driver.md
# exe_issue_driver

Issue-side driver for a single integer execution unit (ALU plus iterative divider). It sits between the issue queue and the execution unit. It buffers up to DEPTH micro-ops in age order and selects the oldest one whose functional-unit code the unit currently accepts, as reported on the unit's fu_types output. It drives the unit's registered request port and applies branch resolve, branch mispredict and flush to both the buffered micro-ops and the micro-op in flight.

## Interface
- DEPTH, 4, number of buffer entries; allowed range 2..8.
- clock  in  1  single clock for all state.
- reset  in  1  asynchronous, active-high; clears all state.
- io_enq_valid  in  1  a micro-op is offered.
- io_enq_ready  out  1  buffer can accept a micro-op.
- io_enq_bits_uopc / fu_code / br_mask / rob_idx / pdst  in  7/10/20/7/7  micro-op fields.
- io_enq_bits_rs1_data, io_enq_bits_rs2_data  in  65  operands.
- io_fu_types  in  10  unit availability mask: bit0 is ALU, bit4 is DIV.
- io_brupdate_b1_resolve_mask, io_brupdate_b1_mispredict_mask  in  20  branch update.
- io_flush  in  1  pipeline flush.
- io_req_valid  out  1  request to the execution unit. There is no ready; a request is consumed when valid.
- io_req_bits_uopc / fu_code / br_mask / rob_idx / pdst / rs1_data / rs2_data  out  mirror of the enq fields.
- io_req_bits_kill  out  1  the in-flight request is dead.
- io_count  out  log2(DEPTH)+1  number of occupied entries.

## Operation
- Storage is a collapsing queue. Entry 0 is the oldest. Each entry holds valid plus all enq fields.
- Eligibility:
  - An entry is eligible if it is valid and (fu_code & io_fu_types) != 0.
  - It must also not be killed this cycle: (br_mask & mispredict_mask) == 0 and io_flush = 0.
- Select: choose the lowest-index eligible entry. Load it into the output register and remove it from the queue.
- Kill:
  - Entries with br_mask & mispredict_mask != 0 are invalidated in the same cycle. Several entries may be removed at once.
  - io_flush invalidates every entry.
- Resolve: each surviving entry and the output register update br_mask &= ~resolve_mask every cycle.
- Compaction: after selection and kills, the surviving entries shift toward index 0 and keep their relative order.
- Enqueue:
  - io_enq_ready = (io_count != DEPTH), taken from the registered count. It does not credit same-cycle removals.
  - An accepted micro-op is written behind the compacted survivors.
  - Its br_mask is cleared of resolve_mask bits before it is stored.
  - If enq br_mask hits mispredict_mask, or io_flush is high, the micro-op is accepted and then dropped.
- io_count is the next-state occupancy, registered.
- Output register:
  - io_req_valid is set on the cycle after a selection and held for exactly one cycle.
  - io_req_bits_kill = io_req_valid & (io_flush | |(io_req_bits_br_mask & mispredict_mask)). This path is combinational.

## Timing
- Reset values: io_req_valid=0, io_req_bits_*=0, io_req_bits_kill=0, io_count=0, io_enq_ready=1. All entries are invalid.
- Latency:
  - Enqueue handshake at edge N makes the entry visible in cycle N+1.
  - The earliest io_req_valid is cycle N+2.
- At most one issue per cycle. Back-to-back issue is allowed whenever io_fu_types permits.
- Divider busy: the unit clears io_fu_types[4] in the same cycle a DIV request is valid. The driver must not select a second DIV in the cycle after one issues.
- A full queue with a simultaneous issue still deasserts io_enq_ready that cycle.
- A mispredict in the same cycle as selection: a killed entry is never selected, and the next-oldest eligible entry is selected instead.
- Reset asserted mid-operation clears everything asynchronously. io_req_valid drops immediately.

## Configuration
- EXE_ISSUE_DRIVER_BYPASS_EN defined:
  - When the queue is empty and the enq micro-op is eligible, it loads the output register directly and is never written to the queue.
  - Earliest io_req_valid is then cycle N+1.
- Undefined: every micro-op passes through the queue, giving a minimum latency of 2 cycles.

## Test plan
- ALU stream: enqueue 4 micro-ops with fu_code=0x001 and io_fu_types=0x011. Expect 4 consecutive io_req_valid cycles in rob_idx order 0,1,2,3, starting 2 cycles after the first enqueue (1 cycle with bypass).
- Divider blocking:
  - Enqueue DIV (fu_code=0x010, rob 5) then ALU (rob 6). io_fu_types=0x001 while DIV is blocked.
  - Expect rob 6 issued first, then rob 5 once io_fu_types[4]=1.
- Mispredict partial kill:
  - Queue holds br_mask 0x1, 0x2, 0x1, 0x0. Pulse mispredict_mask=0x1.
  - Expect io_count to go from 4 to 2, and the survivors in order are the entries with masks 0x2 and 0x0.
- Resolve and kill in flight:
  - Pulse resolve_mask=0x2: the in-queue br_mask goes from 0x2 to 0x0.
  - A mispredict that hits the in-flight request asserts io_req_bits_kill=1 in that same cycle.
- Full queue: with DEPTH=4 and io_fu_types=0, enqueue 5 micro-ops. Expect io_enq_ready=0 after the 4th; io_flush then gives io_count=0 and io_enq_ready=1 on the next cycle.
- Async reset asserted mid-issue: io_req_valid=0 within the same cycle, with no clock edge required.
